// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step/halt sequencer.
//   - FSM state encoding (ST_*), exported on the sequencer's state port
//   - rate select codes (HZ_*) for choose_Hz
//   - div_minus_one(): terminal count for a tick divider
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned HZ_W    = 2;
  localparam int unsigned CNT_W   = 32;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'b01;
  localparam logic [STATE_W-1:0] ST_STEP = 2'b10;
  localparam logic [STATE_W-1:0] ST_HALT = 2'b11;

  localparam logic [HZ_W-1:0] HZ_1000 = 2'b00;
  localparam logic [HZ_W-1:0] HZ_100  = 2'b01;
  localparam logic [HZ_W-1:0] HZ_10   = 2'b10;
  localparam logic [HZ_W-1:0] HZ_1    = 2'b11;

  // Terminal value of the tick counter for a divide-by-div period.
  function automatic logic [CNT_W-1:0] div_minus_one(input int unsigned div);
    return CNT_W'(div - 1);
  endfunction

endpackage

// File: rtl/go_conditioner.sv
// Go button conditioning: 2-FF synchronizer, optional debounce filter and
// rising-edge detector producing a registered one-cycle go_rise pulse.
// Latency from go rising to go_rise high is 3 clk cycles (plus
// DEBOUNCE_CYCLES when the filter is built).
// Build option: define GO_DEBOUNCE_EN to insert the debounce filter.
// Ports:
//   clk      in   system clock
//   clr      in   asynchronous active-low reset
//   go       in   raw Go button, asynchronous to clk
//   go_rise  out  one-cycle pulse per accepted Go press
module go_conditioner
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic go,
  output logic go_rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic level_prev_q, level_prev_d;
  logic go_rise_q, go_rise_d;
  logic level_c;

`ifdef GO_DEBOUNCE_EN
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             filt_q, filt_d;

  // Filtered level follows the synchronized input only after it has held a
  // new value for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign level_c = filt_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES != 0);
  assign level_c         = sync2_q;
`endif

  // Synchronizer chain and rising-edge detect on the conditioned level.
  always_comb begin
    sync1_d      = go;
    sync2_d      = sync1_q;
    level_prev_d = level_c;
    go_rise_d    = level_c & ~level_prev_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_prev_q <= 1'b0;
      go_rise_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_prev_q <= level_prev_d;
      go_rise_q    <= go_rise_d;
    end
  end

  assign go_rise = go_rise_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the MIPS CPU. Issues a one-cycle clock-enable
// (cpu_en) either at a selectable rate (free run) or once per Go press
// (single step), parks in HALT on a CPU halt request, and counts issued
// enable pulses.
// Build option: define GO_DEBOUNCE_EN to debounce the Go button.
// Ports:
//   clk         in   system clock
//   clr         in   asynchronous active-low reset
//   choose_Hz   in   rate select, 00 fastest .. 11 slowest
//   run_mode    in   1 = free run on Go, 0 = single step on Go
//   go          in   raw Go button
//   cpu_halt    in   CPU halt request (level, synchronous)
//   cpu_en      out  one-cycle CPU clock-enable pulse
//   state       out  FSM state (00 IDLE, 01 RUN, 10 STEP, 11 HALT)
//   halted      out  high while in HALT
//   step_count  out  number of cpu_en pulses since reset (wraps)
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_0           = 100_000,
  parameter int unsigned DIV_1           = 1_000_000,
  parameter int unsigned DIV_2           = 10_000_000,
  parameter int unsigned DIV_3           = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [HZ_W-1:0]    choose_Hz,
  input  logic               run_mode,
  input  logic               go,
  input  logic               cpu_halt,
  output logic               cpu_en,
  output logic [STATE_W-1:0] state,
  output logic               halted,
  output logic [CNT_W-1:0]   step_count
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               cpu_en_q, cpu_en_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   step_count_q, step_count_d;
  logic [CNT_W-1:0]   tick_q, tick_d;
  logic [HZ_W-1:0]    hz_q, hz_d;
  logic               skip_halt_q, skip_halt_d;

  logic               go_rise;
  logic               hz_changed;
  logic               halt_chk;
  logic [CNT_W-1:0]   div_m1;

  go_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_go_conditioner (
    .clk     (clk),
    .clr     (clr),
    .go      (go),
    .go_rise (go_rise)
  );

  // Terminal tick count for the registered rate select.
  always_comb begin
    div_m1 = div_minus_one(DIV_0);
    case (hz_q)
      HZ_1000: div_m1 = div_minus_one(DIV_0);
      HZ_100:  div_m1 = div_minus_one(DIV_1);
      HZ_10:   div_m1 = div_minus_one(DIV_2);
      HZ_1:    div_m1 = div_minus_one(DIV_3);
      default: div_m1 = div_minus_one(DIV_0);
    endcase
  end

  // A new switch value is seen the cycle before it is registered; that edge
  // restarts the period so the first tick at the new rate is a full period.
  assign hz_changed = (choose_Hz != hz_q);

  // Next state, tick counter and enable pulse.
  always_comb begin
    state_d     = state_q;
    cpu_en_d    = 1'b0;
    tick_d      = '0;
    skip_halt_d = 1'b0;
    hz_d        = choose_Hz;
    // Right after leaving HALT the still-asserted halt request is ignored
    // for one cycle so the CPU can advance past the syscall.
    halt_chk    = cpu_halt & ~skip_halt_q;

    case (state_q)
      ST_IDLE: begin
        if (halt_chk) begin
          state_d = ST_HALT;
        end else if (go_rise) begin
          if (run_mode) begin
            state_d = ST_RUN;
          end else begin
            state_d  = ST_STEP;
            cpu_en_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (halt_chk) begin
          state_d = ST_HALT;
        end else if (go_rise || !run_mode) begin
          state_d = ST_IDLE;
        end else if (hz_changed) begin
          tick_d = '0;
        end else if (tick_q == div_m1) begin
          cpu_en_d = 1'b1;
          tick_d   = '0;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end

      ST_STEP: begin
        // The entry pulse was issued on the way in; one cycle here only.
        if (halt_chk) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HALT: begin
        if (go_rise) begin
          skip_halt_d = 1'b1;
          if (run_mode) begin
            state_d = ST_RUN;
          end else begin
            state_d  = ST_STEP;
            cpu_en_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    halted_d     = (state_d == ST_HALT);
    step_count_d = cpu_en_d ? (step_count_q + CNT_W'(1)) : step_count_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= ST_IDLE;
      cpu_en_q     <= 1'b0;
      halted_q     <= 1'b0;
      step_count_q <= '0;
      tick_q       <= '0;
      hz_q         <= HZ_1000;
      skip_halt_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_en_q     <= cpu_en_d;
      halted_q     <= halted_d;
      step_count_q <= step_count_d;
      tick_q       <= tick_d;
      hz_q         <= hz_d;
      skip_halt_q  <= skip_halt_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign state      = state_q;
  assign halted     = halted_q;
  assign step_count = step_count_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/halt sequencer for the MIPS CPU. Produces a one-cycle clock-enable `cpu_en` at a selectable rate from the system clock, replacing free-running divided-clock stepping. The Go button either starts free-run mode or advances exactly one instruction. The CPU halt request parks the sequencer until Go is pressed. It sits between the board inputs (Go, rate switches) and the CPU clock-enable input, and it exports an executed-step counter for the display mux.

Parameters:
- DIV_0, 100_000: sys-clock cycles per tick for choose_Hz=00 (1000 Hz at 100 MHz).
- DIV_1, 1_000_000: cycles per tick for choose_Hz=01 (100 Hz).
- DIV_2, 10_000_000: cycles per tick for choose_Hz=10 (10 Hz).
- DIV_3, 100_000_000: cycles per tick for choose_Hz=11 (1 Hz).
- DEBOUNCE_CYCLES, 1_000_000: stable cycles required on Go (only with GO_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock; the only clock.
- clr  in  1  reset, asynchronous, active-low.
- choose_Hz  in  2  rate select; 00 is fastest, 11 is slowest.
- run_mode  in  1  1 = free run on Go; 0 = single step on Go.
- go  in  1  raw Go button, asynchronous to clk.
- cpu_halt  in  1  CPU halt request (syscall), level, synchronous to clk.
- cpu_en  out  1  one-cycle CPU clock-enable pulse.
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALT.
- halted  out  1  high while state is HALT.
- step_count  out  32  number of cpu_en pulses since reset; wraps modulo 2^32.

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, cpu_en=0, halted=0, step_count=0, tick counter=0, synchronizer and edge registers=0.
- Go input path:
  - go passes through a 2-FF synchronizer, then a rising-edge detector, producing go_rise.
  - go_rise is a one-cycle pulse, seen 3 clk cycles after go rises (no debounce).
- Priority in IDLE, RUN and STEP: cpu_halt=1 moves to HALT on the next edge and overrides go_rise.
- IDLE:
  - go_rise with run_mode=1 goes to RUN.
  - go_rise with run_mode=0 goes to STEP.
  - Otherwise the state holds. cpu_en=0.
- RUN:
  - The tick counter increments each cycle.
  - When counter == DIV_sel-1: cpu_en=1 for that single cycle and the counter returns to 0.
  - go_rise or run_mode=0 goes to IDLE and clears the counter. No pulse is issued on that cycle.
- STEP:
  - cpu_en=1 for exactly the first cycle in STEP (one cycle after go_rise), then the next state is IDLE.
  - The rate select is ignored in STEP.
- HALT:
  - cpu_en=0 and halted=1.
  - go_rise moves to RUN if run_mode=1, else to STEP. This holds even if cpu_halt is still high, so the CPU can advance past the syscall.
  - On the cycle after leaving HALT, cpu_halt is not re-evaluated; it is re-evaluated from the second cycle onward.
- cpu_en and cpu_halt in the same cycle: the pulse is still delivered, step_count still increments, and the next state is HALT.
- Rate change: choose_Hz is registered. Any change clears the tick counter on the following cycle, so the first tick at the new rate comes a full DIV_new after the change. No partial period and no double pulse.
- DIV_sel is chosen by the registered choose_Hz. The counter is 32 bits unsigned. DIV values must be ≥2.
- step_count increments on every cycle where cpu_en=1 and wraps from 0xFFFF_FFFF to 0.
- Outputs are registered. cpu_en never stays high for two consecutive cycles.

Optional Feature:
- Macro: GO_DEBOUNCE_EN.
- Defined:
  - The synchronized go must hold a new level for DEBOUNCE_CYCLES consecutive cycles before the filtered level updates.
  - go_rise is derived from the filtered level, adding DEBOUNCE_CYCLES of latency.
  - A glitch shorter than DEBOUNCE_CYCLES produces no go_rise.
- Undefined: only the 2-FF synchronizer is used. The DEBOUNCE_CYCLES parameter is present but unused.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_STEP, ST_HALT;
  - rate select codes HZ_1000, HZ_100, HZ_10, HZ_1.
- One sub-module, go_conditioner. It contains the synchronizer, the optional debounce and the edge detect, and outputs go_rise. The FSM, tick counter and step counter remain in cpu_run_ctrl.

Test Plan:
- Reset and IDLE hold: parameters DIV_0=4, DIV_1=8, DIV_2=16, DIV_3=32. Hold clr=0 for 3 cycles then release; leave go=0 for 50 cycles → state=00, cpu_en never high, step_count=0.
- Free run at 00: run_mode=1, choose_Hz=00, pulse go → RUN, cpu_en pulses every 4 cycles. After 10 pulses step_count=10. A second go → IDLE with no further pulses.
- Single step: run_mode=0, press go 3 times with 20-cycle gaps → exactly 3 single-cycle cpu_en pulses, each 4 cycles after go rises. step_count=3 and state returns to 00.
- Halt and resume: during RUN assert cpu_halt on a cpu_en cycle → that pulse counted, state=11, halted=1, no pulses for 100 cycles. Then pulse go with cpu_halt still 1 and run_mode=0 → exactly one cpu_en, after which the FSM returns to HALT.
- Rate change mid-count: in RUN at 00, switch to 11 two cycles after a pulse → next pulse exactly 33 cycles after the switch (1-cycle register delay plus DIV_3=32). Subsequent gaps are 32 cycles.
- Debounce (GO_DEBOUNCE_EN, DEBOUNCE_CYCLES=10): a 5-cycle go glitch → no state change. A 20-cycle press → go_rise once, cpu_en issued.
